// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: merges hps joysticks and the PS/2 keyboard into
// active-low per-player controls. It also resolves opposing directions
// (SOCD), applies per-button autofire and stretches coin pulses.
// Ports:
//   clk_sys, reset     : clock and synchronous active-high reset
//   vblank             : frame marker, a rising edge is one frame tick
//   joystick_in        : 16 bits per player {.., btn i at 4+i, up, down, left, right}
//   ps2_key            : [10] toggle, [9] pressed, [7:0] scancode
//   af_mask            : per-button autofire enable, BUTTONS bits per player
//   joystick_n         : per player {up,down,left,right}, active low
//   buttons_n          : per player action buttons, active low
//   start_n, coin_n    : per player, active low
//   pause_btn          : active high, any pause source
module arcade_input_mapper #(
  parameter int unsigned PLAYERS        = 2,
  parameter int unsigned BUTTONS        = 4,
  parameter int unsigned START_BIT      = 10,
  parameter int unsigned COIN_BIT       = 11,
  parameter int unsigned PAUSE_BIT      = 12,
  parameter int unsigned AF_FRAMES      = 2,
  parameter int unsigned COIN_FRAMES    = 3,
  parameter int unsigned KB_ALL_PLAYERS = 0
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic                         vblank,
  input  logic [16*PLAYERS-1:0]        joystick_in,
  input  logic [10:0]                  ps2_key,
  input  logic [BUTTONS*PLAYERS-1:0]   af_mask,
  output logic [4*PLAYERS-1:0]         joystick_n,
  output logic [BUTTONS*PLAYERS-1:0]   buttons_n,
  output logic [PLAYERS-1:0]           start_n,
  output logic [PLAYERS-1:0]           coin_n,
  output logic                         pause_btn
);

  localparam int unsigned AF_W = (AF_FRAMES > 1) ? $clog2(AF_FRAMES) : 1;
  localparam int unsigned CN_W = (COIN_FRAMES > 0) ? $clog2(COIN_FRAMES + 1) : 1;
  localparam logic [AF_W-1:0] AF_LAST = AF_W'(AF_FRAMES - 1);
  localparam logic [CN_W-1:0] CN_LOAD = CN_W'(COIN_FRAMES);

  // Keyboard state: one held bit per mapped key
  logic       toggle_q;
  logic [3:0] kb_dir;      // {up,down,left,right}
  logic [1:0] kb_btn;
  logic [1:0] kb_start;
  logic [1:0] kb_coin;
  logic       kb_pause;

  always_ff @(posedge clk_sys) begin
    toggle_q <= ps2_key[10];
    if (reset) begin
      kb_dir   <= '0;
      kb_btn   <= '0;
      kb_start <= '0;
      kb_coin  <= '0;
      kb_pause <= 1'b0;
    end else if (ps2_key[10] != toggle_q) begin
      case (ps2_key[7:0])
        8'h16:   kb_start[0] <= ps2_key[9];
        8'h1E:   kb_start[1] <= ps2_key[9];
        8'h2E:   kb_coin[0]  <= ps2_key[9];
        8'h36:   kb_coin[1]  <= ps2_key[9];
        8'h4D:   kb_pause    <= ps2_key[9];
        8'h75:   kb_dir[3]   <= ps2_key[9];
        8'h72:   kb_dir[2]   <= ps2_key[9];
        8'h6B:   kb_dir[1]   <= ps2_key[9];
        8'h74:   kb_dir[0]   <= ps2_key[9];
        8'h14:   kb_btn[0]   <= ps2_key[9];
        8'h11:   kb_btn[1]   <= ps2_key[9];
        default: ;
      endcase
    end
  end

  // Frame tick from a registered vblank edge detector
  logic vblank_q;
  logic tick;

  always_ff @(posedge clk_sys) begin
    if (reset) vblank_q <= 1'b0;
    else       vblank_q <= vblank;
  end

  assign tick = vblank & ~vblank_q;

  // Player-1 keys only exist when there is a second player
  logic [PLAYERS-1:0] kb_start_p;
  logic [PLAYERS-1:0] kb_coin_p;
  logic [BUTTONS-1:0] kb_btn_b;

  assign kb_start_p = PLAYERS'(kb_start);
  assign kb_coin_p  = PLAYERS'(kb_coin);
  assign kb_btn_b   = BUTTONS'(kb_btn);

  logic [4*PLAYERS-1:0]       joystick_d;
  logic [BUTTONS*PLAYERS-1:0] buttons_d;
  logic [PLAYERS-1:0]         start_d;
  logic [PLAYERS-1:0]         coin_d;
  logic [PLAYERS-1:0]         pause_vec;

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    localparam bit KB_EN = (p == 0) || (KB_ALL_PLAYERS != 0);

    logic [15:0]        joy;
    logic [3:0]         dir_raw;
    logic [3:0]         dir_clean;
    logic [BUTTONS-1:0] btn_raw;
    logic [BUTTONS-1:0] mask;
    logic               af_active;
    logic [AF_W-1:0]    af_cnt;
    logic               af_phase;
    logic               coin_raw;
    logic               coin_q;
    logic [CN_W-1:0]    coin_cnt;

    assign joy     = joystick_in[16*p +: 16];
    assign mask    = af_mask[BUTTONS*p +: BUTTONS];
    assign dir_raw = joy[3:0] | (KB_EN ? kb_dir : 4'b0000);
    assign btn_raw = joy[4 +: BUTTONS] | (KB_EN ? kb_btn_b : BUTTONS'(0));

    // Opposing directions on one axis cancel; the other axis passes
    assign dir_clean[3:2] = (dir_raw[3] & dir_raw[2]) ? 2'b00 : dir_raw[3:2];
    assign dir_clean[1:0] = (dir_raw[1] & dir_raw[0]) ? 2'b00 : dir_raw[1:0];

    assign af_active = |(btn_raw & mask);
    assign coin_raw  = joy[COIN_BIT] | kb_coin_p[p];

    // Autofire: phase starts high so a fresh press asserts at once
    always_ff @(posedge clk_sys) begin
      if (reset || !af_active) begin
        af_cnt   <= '0;
        af_phase <= 1'b1;
      end else if (tick) begin
        if (af_cnt == AF_LAST) begin
          af_cnt   <= '0;
          af_phase <= ~af_phase;
        end else begin
          af_cnt <= af_cnt + AF_W'(1);
        end
      end
    end

    // Coin stretch: a rising edge (re)loads, ticks count down; load wins
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        coin_q   <= 1'b0;
        coin_cnt <= '0;
      end else begin
        coin_q <= coin_raw;
        if (coin_raw && !coin_q)                coin_cnt <= CN_LOAD;
        else if (tick && (coin_cnt != '0))      coin_cnt <= coin_cnt - CN_W'(1);
      end
    end

    assign joystick_d[4*p +: 4]             = ~dir_clean;
    assign buttons_d[BUTTONS*p +: BUTTONS]  = ~(btn_raw & ({BUTTONS{af_phase}} | ~mask));
    assign start_d[p]                       = ~(joy[START_BIT] | kb_start_p[p]);
    assign coin_d[p]                        = ~(coin_raw | (coin_cnt != '0));
    assign pause_vec[p]                     = joy[PAUSE_BIT];
  end

  // Output register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      joystick_n <= '1;
      buttons_n  <= '1;
      start_n    <= '1;
      coin_n     <= '1;
      pause_btn  <= 1'b0;
    end else begin
      joystick_n <= joystick_d;
      buttons_n  <= buttons_d;
      start_n    <= start_d;
      coin_n     <= coin_d;
      pause_btn  <= kb_pause | (|pause_vec);
    end
  end

  // Bits of the hps words that carry no mapped control
  logic unused_bits;
  assign unused_bits = ^{ps2_key[8], joystick_in};

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper (PLAYERS=2, BUTTONS=4, AF_FRAMES=2,
// COIN_FRAMES=3) plus a COIN_FRAMES=0 instance for coin passthrough.
module tb_arcade_input_mapper;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        vblank;
  logic [31:0] joystick_in;
  logic [10:0] ps2_key;
  logic [7:0]  af_mask;
  logic [7:0]  joystick_n;
  logic [7:0]  buttons_n;
  logic [1:0]  start_n;
  logic [1:0]  coin_n;
  logic        pause_btn;

  logic [7:0]  pt_unused_joy;
  logic [7:0]  pt_unused_btn;
  logic [1:0]  pt_unused_start;
  logic [1:0]  pt_coin_n;
  logic        pt_unused_pause;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper dut (
    .clk_sys(clk_sys), .reset(reset), .vblank(vblank),
    .joystick_in(joystick_in), .ps2_key(ps2_key), .af_mask(af_mask),
    .joystick_n(joystick_n), .buttons_n(buttons_n), .start_n(start_n),
    .coin_n(coin_n), .pause_btn(pause_btn)
  );

  arcade_input_mapper #(.COIN_FRAMES(0)) dut_pt (
    .clk_sys(clk_sys), .reset(reset), .vblank(vblank),
    .joystick_in(joystick_in), .ps2_key(ps2_key), .af_mask(af_mask),
    .joystick_n(pt_unused_joy), .buttons_n(pt_unused_btn), .start_n(pt_unused_start),
    .coin_n(pt_coin_n), .pause_btn(pt_unused_pause)
  );

  // Scoreboard: expectations queued at stimulus time, compared after latency
  localparam int SEL_JOY = 0, SEL_BTN = 1, SEL_START = 2, SEL_COIN = 3,
                 SEL_PAUSE = 4, SEL_PTCOIN = 5;

  int          sel_q[$];
  string       tag_q[$];
  logic [31:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      SEL_JOY:    return {24'd0, joystick_n};
      SEL_BTN:    return {24'd0, buttons_n};
      SEL_START:  return {30'd0, start_n};
      SEL_COIN:   return {30'd0, coin_n};
      SEL_PAUSE:  return {31'd0, pause_btn};
      default:    return {30'd0, pt_coin_n};
    endcase
  endfunction

  task automatic expect_val(input int sel, input string tag, input logic [31:0] val);
    sel_q.push_back(sel);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic check();
    int          sel;
    string       tag;
    logic [31:0] e;
    logic [31:0] got;
    while (sel_q.size() > 0) begin
      sel = sel_q.pop_front();
      tag = tag_q.pop_front();
      e   = exp_q.pop_front();
      got = obs(sel);
      tests++;
      assert (got === e) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", tag, got, e);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic frame();
    vblank = 1'b1;
    cyc(1);
    vblank = 1'b0;
    cyc(1);
  endtask

  task automatic kb(input logic [7:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, 1'b0, code};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every input high
    reset = 1'b1; vblank = 1'b0;
    joystick_in = '1; ps2_key = '1; af_mask = '1;
    cyc(3);
    expect_val(SEL_JOY,    "rst_joy",    32'hFF);
    expect_val(SEL_BTN,    "rst_btn",    32'hFF);
    expect_val(SEL_START,  "rst_start",  32'h3);
    expect_val(SEL_COIN,   "rst_coin",   32'h3);
    expect_val(SEL_PAUSE,  "rst_pause",  32'h0);
    expect_val(SEL_PTCOIN, "rst_ptcoin", 32'h3);
    check();

    // One cycle after release the held inputs appear (all directions cancel)
    reset = 1'b0;
    expect_val(SEL_JOY,    "rel_joy",    32'hFF);
    expect_val(SEL_BTN,    "rel_btn",    32'h00);
    expect_val(SEL_START,  "rel_start",  32'h0);
    expect_val(SEL_COIN,   "rel_coin",   32'h0);
    expect_val(SEL_PAUSE,  "rel_pause",  32'h1);
    expect_val(SEL_PTCOIN, "rel_ptcoin", 32'h0);
    cyc(1);
    check();

    // Drop inputs; the stretched coins expire on the third tick
    joystick_in = '0; af_mask = '0;
    cyc(1);
    expect_val(SEL_PTCOIN, "idle_ptcoin", 32'h3);
    check();
    frame(); frame();
    expect_val(SEL_COIN, "idle_coin_held", 32'h0);
    check();
    frame();
    expect_val(SEL_COIN,  "idle_coin", 32'h3);
    expect_val(SEL_JOY,   "idle_joy",  32'hFF);
    expect_val(SEL_BTN,   "idle_btn",  32'hFF);
    expect_val(SEL_START, "idle_start", 32'h3);
    expect_val(SEL_PAUSE, "idle_pause", 32'h0);
    check();

    // SOCD
    joystick_in[3:0] = 4'b1111;
    expect_val(SEL_JOY, "socd_all", 32'hFF);
    cyc(1); check();
    joystick_in[3:0] = 4'b1001;
    joystick_in[19:16] = 4'b0111;
    expect_val(SEL_JOY, "socd_mixed", 32'hB6);
    cyc(1); check();
    joystick_in = '0;
    cyc(1);

    // Keyboard: two-cycle latency, player 0 only
    kb(8'h75, 1'b1);
    expect_val(SEL_JOY, "kb_up_lat1", 32'hFF);
    cyc(1); check();
    expect_val(SEL_JOY, "kb_up", 32'hF7);
    cyc(1); check();
    kb(8'h75, 1'b0);
    expect_val(SEL_JOY, "kb_up_rel", 32'hFF);
    cyc(2); check();
    kb(8'h5A, 1'b1);
    expect_val(SEL_JOY, "kb_unlisted_joy", 32'hFF);
    expect_val(SEL_BTN, "kb_unlisted_btn", 32'hFF);
    cyc(2); check();
    kb(8'h14, 1'b1);
    expect_val(SEL_BTN, "kb_btn0", 32'hFE);
    cyc(2); check();
    kb(8'h14, 1'b0); cyc(2);
    kb(8'h4D, 1'b1);
    expect_val(SEL_PAUSE, "kb_pause", 32'h1);
    cyc(2); check();
    kb(8'h4D, 1'b0); cyc(2);
    kb(8'h1E, 1'b1);
    expect_val(SEL_START, "kb_start1", 32'h1);
    cyc(2); check();
    kb(8'h1E, 1'b0);
    expect_val(SEL_START, "kb_start1_rel", 32'h3);
    cyc(2); check();

    // Autofire on button 0, button 1 held steady
    af_mask = 8'h01;
    joystick_in[5:4] = 2'b11;
    expect_val(SEL_BTN, "af_press", 32'hFC);
    cyc(1); check();
    frame(); expect_val(SEL_BTN, "af_f1", 32'hFC); check();
    frame(); expect_val(SEL_BTN, "af_f2", 32'hFD); check();
    frame(); expect_val(SEL_BTN, "af_f3", 32'hFD); check();
    frame(); expect_val(SEL_BTN, "af_f4", 32'hFC); check();
    frame(); expect_val(SEL_BTN, "af_f5", 32'hFC); check();
    frame(); expect_val(SEL_BTN, "af_f6", 32'hFD); check();
    joystick_in[4] = 1'b0;
    expect_val(SEL_BTN, "af_release", 32'hFD);
    cyc(1); check();
    joystick_in[4] = 1'b1;
    expect_val(SEL_BTN, "af_repress", 32'hFC);
    cyc(1); check();
    joystick_in = '0; af_mask = '0;
    cyc(1);

    // Coin stretch from a one-cycle pulse
    joystick_in[11] = 1'b1;
    expect_val(SEL_COIN,   "coin_press",   32'h2);
    expect_val(SEL_PTCOIN, "ptcoin_press", 32'h2);
    cyc(1); check();
    joystick_in[11] = 1'b0;
    expect_val(SEL_COIN,   "coin_stretch", 32'h2);
    expect_val(SEL_PTCOIN, "ptcoin_drop",  32'h3);
    cyc(1); check();
    frame(); frame();
    expect_val(SEL_COIN, "coin_tick2", 32'h2); check();
    frame();
    expect_val(SEL_COIN, "coin_tick3", 32'h3); check();

    // Second press after one tick reloads the count
    joystick_in[11] = 1'b1; cyc(1);
    joystick_in[11] = 1'b0; cyc(1);
    frame();
    joystick_in[11] = 1'b1; cyc(1);
    joystick_in[11] = 1'b0; cyc(1);
    frame(); frame();
    expect_val(SEL_COIN, "coin_reload_held", 32'h2); check();
    frame();
    expect_val(SEL_COIN, "coin_reload_end", 32'h3); check();

    // Tick and rising edge together: the load wins
    joystick_in[11] = 1'b1; vblank = 1'b1; cyc(1);
    joystick_in[11] = 1'b0; vblank = 1'b0; cyc(1);
    frame(); frame();
    expect_val(SEL_COIN, "coin_tie_held", 32'h2); check();
    frame();
    expect_val(SEL_COIN, "coin_tie_end", 32'h3); check();

    // Reset mid-pulse clears the stretch
    joystick_in[11] = 1'b1; cyc(1);
    joystick_in[11] = 1'b0; cyc(1);
    frame();
    expect_val(SEL_COIN, "coin_pre_reset", 32'h2); check();
    reset = 1'b1;
    expect_val(SEL_COIN, "coin_in_reset", 32'h3);
    cyc(1); check();
    reset = 1'b0;
    expect_val(SEL_COIN, "coin_post_reset", 32'h3);
    cyc(1); check();
    frame(); frame(); frame();
    expect_val(SEL_COIN, "coin_no_residual", 32'h3); check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
